latch_bank_wr_ctrl: RTL and testbench

//   Write scheduler for a bank of 2**ADDR_W level-sensitive D latches (E/D/Q/Qbar style).

---
 rtl/latch_bank_wr_ctrl.sv | 149 ++++++++++++++
 tb/tb_latch_bank_wr_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_wr_ctrl.sv
// Write scheduler for a bank of level-sensitive D latches: round-robin between two
// requesters, each write sequenced as setup -> enable pulse -> hold -> done.
module latch_bank_wr_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 2,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0,
   input  logic [ADDR_W-1:0]      addr0,
   input  logic [DATA_W-1:0]      data0,
   output logic                   done0,
   input  logic                   req1,
   input  logic [ADDR_W-1:0]      addr1,
   input  logic [DATA_W-1:0]      data1,
   output logic                   done1,
   output logic [DATA_W-1:0]      lat_d,
   output logic [2**ADDR_W-1:0]   lat_e,
   output logic                   busy
);

   localparam int unsigned NLAT    = 2**ADDR_W;
   localparam int unsigned MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                rr_ptr_q;
   logic                gnt_q;
   logic [ADDR_W-1:0]   addr_q;

   logic                grant_c;
   logic                gnt_sel_c;

   logic [DATA_W-1:0]   lat_d_nxt;
   logic [NLAT-1:0]     lat_e_nxt;
   logic                done0_nxt;
   logic                done1_nxt;
   logic                busy_nxt;

   // Arbitration: a lone request wins outright; a tie goes to rr_ptr.
   always_comb begin
      grant_c   = (state_q == IDLE) && (req0 || req1);
      gnt_sel_c = (req0 && req1) ? rr_ptr_q : req1;
   end

   // State register, phase counter and captured grant context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rr_ptr_q <= 1'b0;
         gnt_q    <= 1'b0;
         addr_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         if (grant_c) begin
            rr_ptr_q <= ~gnt_sel_c;
            gnt_q    <= gnt_sel_c;
            addr_q   <= gnt_sel_c ? addr1 : addr0;
         end
      end
   end

   // Next-state logic; each timed phase exits when its down-counter reaches zero.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (req0 || req1) state_nxt = SETUP;
         SETUP:   if (cnt_q == '0)  state_nxt = PULSE;
         PULSE:   if (cnt_q == '0)  state_nxt = HOLD;
         HOLD:    if (cnt_q == '0)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Phase counter loads length-1 on phase entry, then counts down to zero.
   always_comb begin
      cnt_nxt = cnt_q;
      if (state_nxt != state_q) begin
         case (state_nxt)
            SETUP:   cnt_nxt = CNT_W'(SETUP_CYC - 1);
            PULSE:   cnt_nxt = CNT_W'(PULSE_CYC - 1);
            HOLD:    cnt_nxt = CNT_W'(HOLD_CYC - 1);
            default: cnt_nxt = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_nxt = cnt_q - CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state so the registered copies line up with it.
   always_comb begin
      lat_d_nxt = lat_d;
      lat_e_nxt = '0;
      done0_nxt = 1'b0;
      done1_nxt = 1'b0;
      busy_nxt  = (state_nxt != IDLE);
      if (grant_c) begin
         lat_d_nxt = gnt_sel_c ? data1 : data0;
      end
      if (state_nxt == PULSE) begin
         lat_e_nxt = NLAT'(1) << addr_q;
      end
      if (state_nxt == DONE) begin
         done0_nxt = ~gnt_q;
         done1_nxt = gnt_q;
      end
   end

   // Output registers; reset clears lat_e without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_d <= '0;
         lat_e <= '0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         busy  <= 1'b0;
      end else begin
         lat_d <= lat_d_nxt;
         lat_e <= lat_e_nxt;
         done0 <= done0_nxt;
         done1 <= done1_nxt;
         busy  <= busy_nxt;
      end
   end

   // A latch enable may only be high while a write is in flight, and for one latch.
   a_lat_e_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lat_e));
   a_lat_e_busy:   assert property (@(posedge clk) disable iff (!rst_n) (lat_e != '0) |-> busy);
   a_done_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(done0 && done1));

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl: scoreboard of expected writes vs. writes observed
// on lat_e/lat_d/done, plus a per-cycle monitor of the enable/data invariants.
module tb_latch_bank_wr_ctrl;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned NLAT   = 4;

   typedef struct packed {
      logic              id;
      logic [NLAT-1:0]   e;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0  = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0;
   logic [DATA_W-1:0] data0 = '0;
   logic              done0;
   logic              req1  = 1'b0;
   logic [ADDR_W-1:0] addr1 = '0;
   logic [DATA_W-1:0] data1 = '0;
   logic              done1;
   logic [DATA_W-1:0] lat_d;
   logic [NLAT-1:0]   lat_e;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   wr_t exp_q[$];
   wr_t obs_q[$];

   latch_bank_wr_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .data0(data0), .done0(done0),
      .req1(req1), .addr1(addr1), .data1(data1), .done1(done1),
      .lat_d(lat_d), .lat_e(lat_e), .busy(busy)
   );

   always #5 clk = ~clk;

   // Per-cycle invariants: lat_e zero/one-hot, lat_d stable while enabled, never both moving.
   logic [DATA_W-1:0] prev_d;
   logic [NLAT-1:0]   prev_e;
   bit                prev_ok = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ok = 1'b0;
      end else begin
         n_checks++;
         if (!$onehot0(lat_e)) begin
            n_fail++;
            $display("FAIL inv_onehot: lat_e=%b required zero or one-hot", lat_e);
         end
         if (prev_ok && lat_e != '0) begin
            n_checks++;
            if (lat_d !== prev_d) begin
               n_fail++;
               $display("FAIL inv_d_stable: lat_d=%h required %h while lat_e=%b", lat_d, prev_d, lat_e);
            end
         end
         if (prev_ok && (lat_e !== prev_e) && (lat_d !== prev_d)) begin
            n_checks++;
            n_fail++;
            $display("FAIL inv_same_cycle: lat_e %b->%b and lat_d %h->%h together, required not both",
                     prev_e, lat_e, prev_d, lat_d);
         end
         prev_d  = lat_d;
         prev_e  = lat_e;
         prev_ok = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0  = 1'b0;
      req1  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   // Runs cycles until n done pulses are seen (or budget runs out), logging observed writes.
   task automatic run_writes(input int n, input int budget, input bit auto_drop, output int got);
      logic [NLAT-1:0]   last_e;
      logic [DATA_W-1:0] last_d;
      wr_t               w;
      got    = 0;
      last_e = '0;
      last_d = '0;
      for (int c = 0; c < budget && got < n; c++) begin
         tick();
         if (lat_e != '0) begin
            last_e = lat_e;
            last_d = lat_d;
         end
         if (done0 || done1) begin
            w.id = done1;
            w.e  = last_e;
            w.d  = last_d;
            obs_q.push_back(w);
            got++;
            last_e = '0;
            if (auto_drop && done0) req0 = 1'b0;
            if (auto_drop && done1) req1 = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      req0  = 1'b1;
      req1  = 1'b1;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({lat_e, lat_d, done0, done1, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: e=%b d=%h done0=%b done1=%b busy=%b required all zero",
                  lat_e, lat_d, done0, done1, busy);
      end
      repeat (2) tick();
      n_checks++;
      if (busy !== 1'b0 || lat_e !== '0) begin
         n_fail++;
         $display("FAIL reset_held: busy=%b e=%b required 0/0", busy, lat_e);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b done0=%b required 0/0", busy, done0);
      end
   endtask

   task automatic test_single();
      do_reset();
      req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
      tick();  // grant edge
      n_checks++;
      if (lat_d !== 8'hA5 || lat_e !== 4'b0000 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_setup: d=%h e=%b busy=%b required A5/0000/1", lat_d, lat_e, busy);
      end
      for (int c = 2; c <= 3; c++) begin
         tick();
         n_checks++;
         if (lat_e !== 4'b0100 || lat_d !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_pulse_c%0d: e=%b d=%h required 0100/A5", c, lat_e, lat_d);
         end
      end
      tick();
      n_checks++;
      if (lat_e !== 4'b0000 || lat_d !== 8'hA5 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_hold: e=%b d=%h done0=%b required 0000/A5/0", lat_e, lat_d, done0);
      end
      tick();
      n_checks++;
      if (done0 !== 1'b1 || done1 !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_done: done0=%b done1=%b busy=%b required 1/0/1", done0, done1, busy);
      end
      req0 = 1'b0;
      tick();
      n_checks++;
      if (done0 !== 1'b0 || busy !== 1'b0 || lat_d !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_idle: done0=%b busy=%b d=%h required 0/0/A5", done0, busy, lat_d);
      end
   endtask

   task automatic test_rr_pair();
      int  got;
      wr_t x;
      wr_t o;
      do_reset();
      exp_q.delete(); obs_q.delete();
      req0 = 1'b1; addr0 = 2'd0; data0 = 8'h11;
      req1 = 1'b1; addr1 = 2'd3; data1 = 8'h33;
      x.id = 1'b0; x.e = 4'b0001; x.d = 8'h11; exp_q.push_back(x);
      x.id = 1'b1; x.e = 4'b1000; x.d = 8'h33; exp_q.push_back(x);
      run_writes(2, 30, 1'b1, got);
      n_checks++;
      if (got != 2) begin
         n_fail++;
         $display("FAIL rr_pair_count: %0d writes completed, required 2", got);
      end
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL rr_pair_write: missing write, required id=%0d e=%b d=%h", x.id, x.e, x.d);
         end else begin
            o = obs_q.pop_front();
            if (o !== x) begin
               n_fail++;
               $display("FAIL rr_pair_write: id=%0d e=%b d=%h required id=%0d e=%b d=%h",
                        o.id, o.e, o.d, x.id, x.e, x.d);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int  got;
      wr_t x;
      wr_t o;
      do_reset();
      exp_q.delete(); obs_q.delete();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'h10;
      req1 = 1'b1; addr1 = 2'd2; data1 = 8'h21;
      for (int k = 0; k < 4; k++) begin
         x.id = k[0];
         x.e  = k[0] ? 4'b0100 : 4'b0010;
         x.d  = k[0] ? 8'h21 : 8'h10;
         exp_q.push_back(x);
      end
      run_writes(4, 40, 1'b0, got);
      req0 = 1'b0;
      req1 = 1'b0;
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL b2b_count: %0d writes completed, required 4", got);
      end
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_write: missing write, required id=%0d e=%b d=%h", x.id, x.e, x.d);
         end else begin
            o = obs_q.pop_front();
            if (o !== x) begin
               n_fail++;
               $display("FAIL b2b_write: id=%0d e=%b d=%h required id=%0d e=%b d=%h",
                        o.id, o.e, o.d, x.id, x.e, x.d);
            end
         end
      end
      repeat (2) tick();
   endtask

   task automatic test_data_capture();
      int  got;
      wr_t x;
      wr_t o;
      exp_q.delete(); obs_q.delete();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL capture_idle: busy=%b required 0", busy);
      end
      req1 = 1'b1; addr1 = 2'd1; data1 = 8'h5A;
      x.id = 1'b1; x.e = 4'b0010; x.d = 8'h5A; exp_q.push_back(x);
      tick();  // grant edge
      data1 = 8'hFF;
      addr1 = 2'd3;
      n_checks++;
      if (lat_d !== 8'h5A) begin
         n_fail++;
         $display("FAIL capture_setup: d=%h required 5A", lat_d);
      end
      run_writes(1, 20, 1'b1, got);
      n_checks++;
      if (got != 1 || lat_d !== 8'h5A) begin
         n_fail++;
         $display("FAIL capture_done: writes=%0d d=%h required 1/5A", got, lat_d);
      end
      x = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL capture_write: missing write, required id=%0d e=%b d=%h", x.id, x.e, x.d);
      end else begin
         o = obs_q.pop_front();
         if (o !== x) begin
            n_fail++;
            $display("FAIL capture_write: id=%0d e=%b d=%h required id=%0d e=%b d=%h",
                     o.id, o.e, o.d, x.id, x.e, x.d);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      int  got;
      wr_t x;
      wr_t o;
      do_reset();
      exp_q.delete(); obs_q.delete();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'h77;
      tick();  // grant edge
      tick();
      n_checks++;
      if (lat_e !== 4'b0010) begin
         n_fail++;
         $display("FAIL abort_pulse: e=%b required 0010", lat_e);
      end
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if (lat_e !== 4'b0000 || busy !== 1'b0 || lat_d !== 8'h00 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async: e=%b busy=%b d=%h done0=%b required 0000/0/00/0",
                  lat_e, busy, lat_d, done0);
      end
      req0 = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      run_writes(1, 8, 1'b1, got);
      n_checks++;
      if (got != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: %0d done pulses, required 0", got);
      end
      obs_q.delete();
      req1 = 1'b1; addr1 = 2'd2; data1 = 8'hC3;
      x.id = 1'b1; x.e = 4'b0100; x.d = 8'hC3; exp_q.push_back(x);
      run_writes(1, 20, 1'b1, got);
      x = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL abort_recover: missing write, required id=%0d e=%b d=%h", x.id, x.e, x.d);
      end else begin
         o = obs_q.pop_front();
         if (o !== x) begin
            n_fail++;
            $display("FAIL abort_recover: id=%0d e=%b d=%h required id=%0d e=%b d=%h",
                     o.id, o.e, o.d, x.id, x.e, x.d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_pair();
      test_back_to_back();
      test_data_capture();
      test_reset_mid_pulse();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
